data_mem_responder: RTL and testbench



---
 rtl/klp32_pkg.sv | 66 ++++++
 rtl/data_mem_responder_ram.sv | 37 +++
 rtl/data_mem_responder.sv | 140 ++++++++++++++
 tb/tb_data_mem_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/klp32_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | klp32_pkg : load/store mode encoding, responder FSM states, lane helpers  |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
package klp32_pkg;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } load_store_mode_e;

  typedef logic [1:0] dmr_state_t;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_wait = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  // Pick the addressed lane out of a RAM word and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  mode);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (mode)
      LS_B:    return {{24{b[7]}}, b};
      LS_H:    return {{16{h[15]}}, h};
      LS_W:    return word;
      LS_BU:   return {24'h0, b};
      LS_HU:   return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] store_byte_enable(input logic [2:0] mode,
                                                   input logic [1:0] lane);
    case (mode)
      LS_B:    return 4'b0001 << lane;
      LS_H:    return lane[1] ? 4'b1100 : 4'b0011;
      LS_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data so every candidate lane carries it.
  function automatic logic [31:0] store_lanes(input logic [2:0]  mode,
                                              input logic [31:0] wdata);
    case (mode)
      LS_B:    return {4{wdata[7:0]}};
      LS_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_ram : DEPTH_WORDS x 32 single-port RAM, byte enables, registered rd  |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_responder : valid/ready data-memory slave with wait states       |
// | Revision           : 1.0                                                  |
// +--------------------------------------------------------------------------+
module data_mem_responder
  import klp32_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [2:0]  i_req_mode,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int          c_byte_aw    = $clog2(4 * DEPTH_WORDS);
  localparam logic [32:0] c_addr_limit = 33'(4 * DEPTH_WORDS);
  localparam logic        c_zero_wait  = (WAIT_STATES == 0);
  localparam logic [3:0]  c_cnt_load   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  function automatic logic req_error(input logic        we,
                                     input logic [2:0]  mode,
                                     input logic [31:0] addr);
    logic bad_mode;
    logic misaligned;
    bad_mode   = 1'b0;
    misaligned = 1'b0;
    case (mode)
      LS_B, LS_BU: bad_mode = 1'b0;
      LS_H, LS_HU: misaligned = addr[0];
      LS_W:        misaligned = (addr[1:0] != 2'b00);
      default:     bad_mode = 1'b1;
    endcase
    if ((mode == LS_BU || mode == LS_HU) && we) bad_mode = 1'b1;
    return bad_mode | misaligned | ({1'b0, addr} >= c_addr_limit);
  endfunction

  dmr_state_t           r_state;
  logic [3:0]           r_cnt;
  logic                 r_we;
  logic [c_byte_aw-1:0] r_addr;
  logic [31:0]          r_wdata;
  logic [2:0]           r_mode;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_err_live;
  logic                 w_sel_live;
  logic                 w_we_s;
  logic                 w_err_s;
  logic [c_byte_aw-1:0] w_addr_s;
  logic [31:0]          w_wdata_s;
  logic [2:0]           w_mode_s;
  logic                 w_commit;
  logic                 w_ram_wr;
  logic                 w_ram_rd;
  logic [31:0]          w_ram_rdata;

  assign o_req_ready = (r_state == c_st_idle) && !reset;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_err_live  = req_error(i_req_we, i_req_mode, i_req_addr);

  // With no wait states the store commits on the accept edge itself, so the
  // RAM port is fed straight from the request inputs while in IDLE.
  assign w_sel_live = (r_state == c_st_idle);
  assign w_we_s     = w_sel_live ? i_req_we                    : r_we;
  assign w_err_s    = w_sel_live ? w_err_live                  : r_err;
  assign w_addr_s   = w_sel_live ? i_req_addr[c_byte_aw-1:0]   : r_addr;
  assign w_wdata_s  = w_sel_live ? i_req_wdata                 : r_wdata;
  assign w_mode_s   = w_sel_live ? i_req_mode                  : r_mode;

  assign w_commit = (w_accept && c_zero_wait) ||
                    ((r_state == c_st_wait) && (r_cnt == 4'd0));
  assign w_ram_wr = w_commit && w_we_s && !w_err_s && !reset;
  assign w_ram_rd = w_accept && !i_req_we;

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_wr || w_ram_rd),
    .i_we    (w_ram_wr),
    .i_be    (store_byte_enable(w_mode_s, w_addr_s[1:0])),
    .i_addr  (w_addr_s[c_byte_aw-1:2]),
    .i_wdata (store_lanes(w_mode_s, w_wdata_s)),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_mode  <= 3'b000;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_we    <= i_req_we;
            r_addr  <= i_req_addr[c_byte_aw-1:0];
            r_wdata <= i_req_wdata;
            r_mode  <= i_req_mode;
            r_err   <= w_err_live;
            r_cnt   <= c_cnt_load;
            r_state <= c_zero_wait ? c_st_resp : c_st_wait;
          end
        end
        c_st_wait: begin
          if (r_cnt == 4'd0) r_state <= c_st_resp;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        c_st_resp: begin
          if (i_rsp_ready) r_state <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  // The RAM read register only updates on an accepted load, so rdata holds.
  assign o_rsp_valid = (r_state == c_st_resp);
  assign o_rsp_err   = o_rsp_valid && r_err;
  assign o_rsp_rdata = (o_rsp_valid && !r_err && !r_we) ?
                       load_extend(w_ram_rdata, r_addr[1:0], r_mode) : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_mem_responder : scoreboard bench, one zero-wait and one 3-wait DUT|
// | Revision              : 1.0                                               |
// +--------------------------------------------------------------------------+
module tb_data_mem_responder;
  import klp32_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [2:0]  req_mode  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  exp_t exp_q [$];
  int   n_cmp;
  int   n_fail;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_we(req_we[0]),
    .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]), .i_req_mode(req_mode[0]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_we(req_we[1]),
    .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]), .i_req_mode(req_mode[1]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one request, wait for its response, hold rsp_ready low for `hold`
  // cycles, then complete the handshake; expected values go via the queue.
  task automatic transact(input int sel, input logic we, input logic [2:0] mode,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int hold, input string name);
    exp_t e;
    int   n;
    int   ws;
    ws = (sel == 1) ? 3 : 0;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_q.push_back(e);
    n = 0;
    while (req_ready[sel] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    req_we[sel]    = we;
    req_mode[sel]  = mode;
    req_addr[sel]  = addr;
    req_wdata[sel] = wdata;
    req_valid[sel] = 1'b1;
    rsp_ready[sel] = (hold == 0);
    @(posedge clk); #1;
    req_valid[sel] = 1'b0;
    n = 0;
    while (rsp_valid[sel] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (n != ws) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, ws);
    end
    n_cmp++;
    if (rsp_rdata[sel] !== e.rdata || rsp_err[sel] !== e.err || req_ready[sel] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s response: rdata=%h err=%b ready=%b, expected rdata=%h err=%b ready=0",
               name, rsp_rdata[sel], rsp_err[sel], req_ready[sel], e.rdata, e.err);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rsp_valid[sel] !== 1'b1 || rsp_rdata[sel] !== e.rdata ||
          rsp_err[sel] !== e.err || req_ready[sel] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s hold%0d: valid=%b rdata=%h err=%b ready=%b, expected 1 %h %b 0",
                 name, i, rsp_valid[sel], rsp_rdata[sel], rsp_err[sel], req_ready[sel],
                 e.rdata, e.err);
      end
    end
    rsp_ready[sel] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[sel] = 1'b0;
    n_cmp++;
    if (rsp_valid[sel] !== 1'b0 || req_ready[sel] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after handshake: valid=%b ready=%b, expected valid=0 ready=1",
               name, rsp_valid[sel], req_ready[sel]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if (req_ready[s] !== 1'b0 || rsp_valid[s] !== 1'b0 ||
          rsp_rdata[s] !== 32'h0 || rsp_err[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: ready=%b valid=%b rdata=%h err=%b, expected 0 0 0 0",
                 s, req_ready[s], rsp_valid[s], rsp_rdata[s], rsp_err[s]);
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if (req_ready[s] !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_ready dut%0d: ready=%b, expected 1", s, req_ready[s]);
      end
    end
  endtask

  task automatic test_word();
    transact(0, 1'b1, LS_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0, "sw_10");
    transact(0, 1'b0, LS_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, "lw_10");
  endtask

  task automatic test_byte_half();
    transact(0, 1'b1, LS_W,  32'h10, 32'h0,        32'h0,        1'b0, 0, "sw0_10");
    transact(0, 1'b1, LS_B,  32'h13, 32'hFFFF_FF80, 32'h0,       1'b0, 0, "sb_13");
    transact(0, 1'b0, LS_B,  32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 0, "lb_13");
    transact(0, 1'b0, LS_BU, 32'h13, 32'h0, 32'h00000080, 1'b0, 0, "lbu_13");
    transact(0, 1'b0, LS_W,  32'h10, 32'h0, 32'h80000000, 1'b0, 0, "lw_after_sb");
    transact(0, 1'b0, LS_H,  32'h12, 32'h0, 32'hFFFF8000, 1'b0, 0, "lh_12");
    transact(0, 1'b0, LS_HU, 32'h12, 32'h0, 32'h00008000, 1'b0, 0, "lhu_12");
    transact(0, 1'b1, LS_H,  32'h10, 32'hABCD_1234, 32'h0,       1'b0, 0, "sh_10");
    transact(0, 1'b0, LS_W,  32'h10, 32'h0, 32'h80001234, 1'b0, 0, "lw_after_sh");
    transact(0, 1'b0, LS_B,  32'h11, 32'h0, 32'h00000012, 1'b0, 0, "lb_11");
  endtask

  task automatic test_misaligned();
    transact(0, 1'b0, LS_H, 32'h11, 32'h0,         32'h0, 1'b1, 0, "lh_11");
    transact(0, 1'b0, LS_W, 32'h12, 32'h0,         32'h0, 1'b1, 0, "lw_12");
    transact(0, 1'b1, LS_W, 32'h12, 32'hFFFFFFFF,  32'h0, 1'b1, 0, "sw_12");
    transact(0, 1'b1, LS_H, 32'h11, 32'hFFFFFFFF,  32'h0, 1'b1, 0, "sh_11");
    transact(0, 1'b0, LS_W, 32'h10, 32'h0, 32'h80001234, 1'b0, 0, "lw_unchanged");
  endtask

  task automatic test_illegal();
    transact(0, 1'b1, LS_W,   32'h0,    32'h0,        32'h0, 1'b0, 0, "sw0_00");
    transact(0, 1'b0, 3'b011, 32'h10,   32'h0,        32'h0, 1'b1, 0, "mode011");
    transact(0, 1'b1, 3'b100, 32'h10,   32'hFFFFFFFF, 32'h0, 1'b1, 0, "sbu");
    transact(0, 1'b1, 3'b111, 32'h10,   32'hFFFFFFFF, 32'h0, 1'b1, 0, "mode111");
    transact(0, 1'b1, LS_W,   32'h1000, 32'hAAAAAAAA, 32'h0, 1'b1, 0, "sw_oor");
    transact(0, 1'b0, LS_B,   32'h1000, 32'h0,        32'h0, 1'b1, 0, "lb_oor");
    transact(0, 1'b0, LS_W,   32'h0,    32'h0,        32'h0, 1'b0, 0, "lw_00_clean");
    transact(0, 1'b0, LS_W,   32'h10,   32'h0, 32'h80001234, 1'b0, 0, "lw_10_clean");
  endtask

  task automatic test_wait_states();
    transact(1, 1'b1, LS_W, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 0, "ws3_sw_40");
    transact(1, 1'b0, LS_W, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 5, "ws3_lw_40");
    transact(1, 1'b0, LS_H, 32'h41, 32'h0, 32'h0, 1'b1, 5, "ws3_lh_41");
    transact(1, 1'b0, LS_HU, 32'h42, 32'h0, 32'h0000CAFE, 1'b0, 0, "ws3_lhu_42");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      transact(0, 1'b1, LS_B, 32'h80 + i, 32'(8'h11 * (i + 1)), 32'h0, 1'b0, 0, "b2b_sb");
    end
    transact(0, 1'b0, LS_W, 32'h80, 32'h0, 32'h44332211, 1'b0, 0, "b2b_lw");
  endtask

  // Reset lands on the edge where the pending store would commit.
  task automatic test_reset_in_wait();
    int n;
    int seen;
    transact(1, 1'b1, LS_W, 32'h20, 32'h0, 32'h0, 1'b0, 0, "ws3_sw0_20");
    n = 0;
    while (req_ready[1] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    req_we[1]    = 1'b1;
    req_mode[1]  = LS_W;
    req_addr[1]  = 32'h20;
    req_wdata[1] = 32'h12345678;
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid[1] !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    rsp_ready[1] = 1'b0;
    n_cmp++;
    if (seen != 0 || req_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_wait: valid seen %0d cycles, ready=%b, expected 0 cycles ready=1",
               seen, req_ready[1]);
    end
    transact(1, 1'b0, LS_W, 32'h20, 32'h0, 32'h0, 1'b0, 0, "ws3_lw_20_after_reset");
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      req_we[s]    = 1'b0;
      req_addr[s]  = 32'h0;
      req_wdata[s] = 32'h0;
      req_mode[s]  = 3'b000;
      rsp_ready[s] = 1'b0;
    end
    test_reset();
    test_word();
    test_byte_half();
    test_misaligned();
    test_illegal();
    test_wait_states();
    test_back_to_back();
    test_reset_in_wait();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
